uart_tx_arbiter: RTL and testbench

- Shares one uart_tx transmitter between NUM_REQ byte producers, for example a debug console, a status reporter and a loopback echo.
- Uses a round-robin grant and a valid/ready handshake on each requester port.
- Drives the transmitter's data_bus and active-low run start strobe. Holds the byte stable for the whole frame and waits for the transmitter's done pulse before granting again.
- Includes a watchdog that recovers if done never arrives.

---
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_arbiter: round-robin sharing of one uart_tx among NUM_REQ        |
// | byte producers, with a done watchdog.                 Revision: 1.0      |
// +--------------------------------------------------------------------------+
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 17
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data_bus,
  output logic                          tx_run,
  input  logic                          tx_done,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          sent_valid,
  output logic [$clog2(NUM_REQ)-1:0]    sent_id,
  output logic                          timeout_err
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    RECOVER   = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ID_W-1:0]   last_grant;
  logic [CNT_W-1:0]  wd_cnt;
  logic              wd_hit;
  logic              win_found;
  logic [ID_W-1:0]   win_id;

  assign wd_hit = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign busy   = (state != IDLE);

  // Search upward from the requester after the last one granted.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int cand;
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_id    = ID_W'(cand);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && win_found)
      req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_id;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (win_found) state_next = LAUNCH;
      LAUNCH:    state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (tx_done)     state_next = IDLE;
        else if (wd_hit) state_next = RECOVER;
      end
      RECOVER:   state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_run      <= 1'b1;
      tx_data_bus <= '0;
      grant_id    <= '0;
      last_grant  <= ID_W'(NUM_REQ - 1);
      sent_valid  <= 1'b0;
      sent_id     <= '0;
      timeout_err <= 1'b0;
      wd_cnt      <= '0;
    end else begin
      sent_valid  <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            tx_data_bus <= req_data[int'(win_id)*DATA_WIDTH +: DATA_WIDTH];
            grant_id    <= win_id;
            last_grant  <= win_id;
            tx_run      <= 1'b0;
          end
        end
        LAUNCH: begin
          tx_run <= 1'b1;
          wd_cnt <= '0;
        end
        WAIT_DONE: begin
          // Byte and id stay put: uart_tx samples data_bus live per bit.
          wd_cnt <= wd_cnt + CNT_W'(1);
          if (tx_done) begin
            sent_valid <= 1'b1;
            sent_id    <= grant_id;
          end else if (wd_hit) begin
            timeout_err <= 1'b1;
          end
        end
        RECOVER: tx_run <= 1'b1;
        default: tx_run <= 1'b1;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// Randomised scoreboard bench for uart_tx_arbiter with a behavioural uart_tx.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int T   = 60;
  localparam int CW  = 17;
  localparam int CPB = 4;
  localparam int IW  = $clog2(N);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   tx_data_bus;
  logic            tx_run, busy, sent_valid, timeout_err;
  logic [IW-1:0]   grant_id, sent_id;
  logic            uart_done = 1'b0, force_done = 1'b0, done_en = 1'b1;
  logic            tx_done;
  assign tx_done = uart_done | force_done;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data_bus(tx_data_bus), .tx_run(tx_run),
    .tx_done(tx_done), .busy(busy), .grant_id(grant_id), .sent_valid(sent_valid),
    .sent_id(sent_id), .timeout_err(timeout_err)
  );

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural uart_tx: start, 8 data bits LSB first read live, stop, done.
  logic          line = 1'b1;
  logic [DW-1:0] rx_byte = '0, u_byte = '0;
  int            u_pos = 0;
  bit            u_active = 0;
  initial forever begin
    @(posedge clk); #1;
    uart_done = 1'b0;
    if (rst) begin
      u_active = 0; line = 1'b1;
    end else if (u_active) begin
      u_pos++;
      if (u_pos == 10*CPB) begin
        u_active = 0; line = 1'b1; rx_byte = u_byte; uart_done = done_en;
      end else begin
        int idx;
        idx  = u_pos / CPB;
        line = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : tx_data_bus[idx-1];
        if (u_pos % CPB == CPB/2 && idx >= 1 && idx <= 8) u_byte[idx-1] = line;
      end
    end else if (tx_run === 1'b0) begin
      u_active = 1; u_pos = 0; line = 1'b0;
    end
  end

  // Producers: one byte queue per requester; valid while non-empty.
  logic [DW-1:0] prod_q [N][$];
  logic [N-1:0]  hs_pend = '0;
  bit            chk_en = 0;

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (prod_q[i].size() > 0);
      req_data[i*DW +: DW] = (prod_q[i].size() > 0) ? prod_q[i][0] : '0;
    end
  endtask

  task automatic push(input int i, input logic [DW-1:0] b);
    prod_q[i].push_back(b);
    refresh();
  endtask

  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) if (hs_pend[i]) void'(prod_q[i].pop_front());
    refresh();
  endtask

  // Reference model + scoreboard monitor, sampled on the falling edge.
  typedef struct packed { logic [IW-1:0] id; logic [DW-1:0] b; } exp_t;
  exp_t exp_q[$];
  int   sent_log[$];
  int   to_log[$];
  int   m_last = N-1, age = 0;
  bit   inflight = 0, recov = 0, prev_rst = 1;
  bit   nx_launch = 0, nx_busy = 0, nx_sent = 0, nx_to = 0;
  logic [IW-1:0] cur_id = '0;
  logic [DW-1:0] cur_b = '0;

  always @(negedge clk) begin : mon
    exp_t e;
    int   w;
    if (chk_en) begin
      chk("tx_run", tx_run, !nx_launch);
      chk("busy", busy, nx_busy);
      chk("sent_valid", sent_valid, nx_sent);
      chk("timeout_err", timeout_err, nx_to);
      if (nx_busy) begin
        chk("tx_data_bus_hold", tx_data_bus, cur_b);
        chk("grant_id", grant_id, cur_id);
      end
      if (prev_rst) begin
        chk("rst_tx_data_bus", tx_data_bus, 0);
        chk("rst_grant_id", grant_id, 0);
      end
      if (sent_valid) begin
        if (exp_q.size() == 0) chk("sent_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("sent_id", sent_id, e.id);
          chk("frame_byte", rx_byte, e.b);
          sent_log.push_back(int'(sent_id));
        end
      end
      if (timeout_err) begin
        if (exp_q.size() == 0) chk("timeout_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("timeout_id", cur_id, e.id);
          to_log.push_back(int'(e.id));
        end
      end

      nx_launch = 0; nx_sent = 0; nx_to = 0;
      if (rst) begin
        chk("rst_req_ready", req_ready, 0);
        inflight = 0; recov = 0; m_last = N-1; exp_q.delete(); nx_busy = 0;
      end else if (recov) begin
        chk("req_ready_recover", req_ready, 0);
        recov = 0; nx_busy = 0;
      end else if (inflight) begin
        chk("req_ready_busy", req_ready, 0);
        age++;
        if (age >= 2 && tx_done) begin
          nx_sent = 1; inflight = 0; nx_busy = 0;
        end else if (age >= 2 && age - 2 == T - 1) begin
          nx_to = 1; inflight = 0; recov = 1; nx_busy = 1;
        end else nx_busy = 1;
      end else if (req_valid != 0) begin
        w = -1;
        for (int k = 1; k <= N; k++)
          if (w < 0 && req_valid[(m_last + k) % N]) w = (m_last + k) % N;
        chk("req_ready_grant", req_ready, 32'd1 << w);
        cur_id = IW'(w);
        cur_b  = req_data[w*DW +: DW];
        exp_q.push_back('{cur_id, cur_b});
        m_last = w; inflight = 1; age = 0; nx_launch = 1; nx_busy = 1;
      end else begin
        chk("req_ready_idle", req_ready, 0);
        nx_busy = 0;
      end
      prev_rst = rst;
      hs_pend  = req_valid & req_ready;
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    bit pend;
    n = 0;
    do begin
      step();
      n++;
      pend = busy || exp_q.size() != 0;
      for (int i = 0; i < N; i++) if (prod_q[i].size() != 0) pend = 1;
    end while (pend && n < budget);
    if (pend) chk("wait_idle_expired", 1, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, sc, tc;
    push(1, 8'h11);
    @(posedge clk); #1;
    chk_en = 1;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_tx_run", tx_run, 1);
    chk("rst_req_ready_forced", req_ready, 0);
    prod_q[1].delete(); refresh();
    rst = 1'b0;
    step();

    // Single request
    push(0, 8'h55);
    wait_idle(400);
    chk("single_count", sent_log.size(), 1);
    if (sent_log.size() == 1) chk("single_id", sent_log[0], 0);

    // Simultaneous requests from a fresh reset
    do_reset(); sent_log.delete();
    for (int i = 0; i < N; i++) prod_q[i].push_back(8'hA0 + 8'(i));
    refresh();
    wait_idle(800);
    chk("simul_count", sent_log.size(), N);
    for (int i = 0; i < N && i < sent_log.size(); i++) chk("simul_order", sent_log[i], i);

    // Fairness: after 2, pending 1 and 3 -> 3 first
    sent_log.delete();
    push(2, 8'h22);
    wait_idle(400);
    push(1, 8'h61); push(3, 8'h63);
    wait_idle(400);
    chk("fair_count", sent_log.size(), 3);
    if (sent_log.size() == 3) begin
      chk("fair_first", sent_log[1], 3);
      chk("fair_second", sent_log[2], 1);
    end

    // Randomised traffic with occasional drops
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < N; i++) if ($urandom % 3 == 0) push(i, 8'($urandom));
      n = $urandom_range(0, 60);
      repeat (n) begin
        step();
        if ($urandom % 16 == 0) begin
          int d;
          d = $urandom_range(0, N-1);
          if (prod_q[d].size() > 0) begin void'(prod_q[d].pop_front()); refresh(); end
        end
      end
    end
    wait_idle(5000);

    // Watchdog: done suppressed, two pending requesters
    done_en = 1'b0; to_log.delete();
    push(1, 8'h5A); push(2, 8'hA5);
    wait_idle(600);
    chk("wd_count", to_log.size(), 2);
    if (to_log.size() == 2) begin
      chk("wd_first", to_log[0], 1);
      chk("wd_second", to_log[1], 2);
    end

    // Coincident done and timeout: done must win
    sent_log.delete(); to_log.delete();
    push(3, 8'h3C);
    n = 0;
    do begin step(); n++; end while (tx_run !== 1'b0 && n < 50);
    if (tx_run !== 1'b0) chk("coinc_launch_expired", 1, 0);
    repeat (T) step();
    force_done = 1'b1;
    step();
    force_done = 1'b0;
    wait_idle(200);
    chk("coinc_sent", sent_log.size(), 1);
    chk("coinc_timeout", to_log.size(), 0);
    done_en = 1'b1;

    // Reset in the middle of a frame
    sent_log.delete();
    push(2, 8'h77);
    n = 0;
    do begin step(); n++; end while (!busy && n < 50);
    repeat (10) step();
    chk("mid_busy_before", busy, 1);
    rst = 1'b1;
    step();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_tx_run", tx_run, 1);
    chk("mid_rst_req_ready", req_ready, 0);
    step();
    rst = 1'b0;
    repeat (60) step();
    chk("mid_no_sent", sent_log.size(), 0);
    push(3, 8'h33); push(0, 8'h00);
    wait_idle(400);
    chk("mid_after_count", sent_log.size(), 2);
    if (sent_log.size() == 2) chk("mid_priority0", sent_log[0], 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    sc = n_chk; tc = n_fail;
    $display("End of test - %0d assertions evaluated, %0d failures", sc, tc);
    $finish;
  end

endmodule
`default_nettype wire
